// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the multi-cycle multiply/divide unit.
// Imported by the controller, the interface and the top level.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int ITER  = WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        FIX,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_DIV,
        OP_DZ
    } op_e;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Pipeline <-> multiply/divide unit handshake and data bundle.
// master = issuing pipeline, slave = execution unit.
interface multdiv_sequencer_if #(
    parameter int WIDTH = multdiv_pkg::WIDTH
);

    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV,
        output data_operandA, data_operandB,
        input  data_result, data_exception,
        input  data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV,
        input  data_operandA, data_operandB,
        output data_result, data_exception,
        output data_resultRDY, busy
    );

endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencing FSM: iteration counter, busy/ready generation and
// load/iterate/fix strobes for the datapath.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int CNT_W = multdiv_pkg::CNT_W,
    parameter int ITER  = multdiv_pkg::ITER
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mul_i,
    input  logic div_i,
    input  logic b_zero_i,
    output logic load_o,
    output op_e  op_o,
    output logic iter_o,
    output logic fix_o,
    output logic busy_o,
    output logic rdy_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             rdy_q;

    always_comb begin
        load_o = (state_q == IDLE) && (mul_i || div_i);
        op_o   = mul_i ? OP_MUL : (b_zero_i ? OP_DZ : OP_DIV);
        iter_o = (state_q == MUL_RUN) || (state_q == DIV_RUN);
        fix_o  = (state_q == FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_o) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        // divide-by-zero skips iterating; FIX forces the result
                        unique case (op_o)
                            OP_MUL:  state_q <= MUL_RUN;
                            OP_DIV:  state_q <= DIV_RUN;
                            default: state_q <= FIX;
                        endcase
                    end
                end
                MUL_RUN, DIV_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= DONE;
                    rdy_q   <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign rdy_o  = rdy_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// One op in flight; hi/lo/m registers are shared by both algorithms.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = multdiv_pkg::WIDTH,
    parameter int CNT_W = multdiv_pkg::CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    multdiv_sequencer_if.slave  bus
);

    logic load;
    logic iter;
    logic fix;
    op_e  ld_op;
    op_e  op_q;

    // mul: hi:lo:q1 product, m = multiplicand
    // div: hi = remainder, lo = quotient, m = divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q;
    logic             q1_q, q1_d;
    logic             neg_q;
    logic [WIDTH-1:0] res_q;
    logic             exc_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_t;
    logic [WIDTH-1:0] q_fix;
    logic             mul_exc;

    multdiv_ctrl #(
        .CNT_W (CNT_W),
        .ITER  (WIDTH)
    ) u_ctrl (
        .clk      (clock),
        .rst_n    (reset),
        .mul_i    (bus.ctrl_MULT),
        .div_i    (bus.ctrl_DIV),
        .b_zero_i (bus.data_operandB == '0),
        .load_o   (load),
        .op_o     (ld_op),
        .iter_o   (iter),
        .fix_o    (fix),
        .busy_o   (bus.busy),
        .rdy_o    (bus.data_resultRDY)
    );

    always_comb begin
        a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
        b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

        booth_sum = {hi_q[WIDTH-1], hi_q};
        unique case ({lo_q[0], q1_q})
            2'b01:   booth_sum = {hi_q[WIDTH-1], hi_q} + {m_q[WIDTH-1], m_q};
            2'b10:   booth_sum = {hi_q[WIDTH-1], hi_q} - {m_q[WIDTH-1], m_q};
            default: booth_sum = {hi_q[WIDTH-1], hi_q};
        endcase

        // remainder stays below the divisor, so WIDTH+1 bits hold the trial sign
        div_sh = {hi_q, lo_q[WIDTH-1]};
        div_t  = div_sh - {1'b0, m_q};

        hi_d = hi_q;
        lo_d = lo_q;
        q1_d = q1_q;
        if (op_q == OP_MUL) begin
            hi_d = booth_sum[WIDTH:1];
            lo_d = {booth_sum[0], lo_q[WIDTH-1:1]};
            q1_d = lo_q[0];
        end else if (!div_t[WIDTH]) begin
            hi_d = div_t[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_d = div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end

        q_fix   = neg_q ? -lo_q : lo_q;
        mul_exc = (hi_q != {WIDTH{lo_q[WIDTH-1]}});
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q  <= OP_MUL;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            q1_q  <= 1'b0;
            neg_q <= 1'b0;
            res_q <= '0;
            exc_q <= 1'b0;
        end else begin
            if (load) begin
                op_q <= ld_op;
                hi_q <= '0;
                q1_q <= 1'b0;
                if (ld_op == OP_MUL) begin
                    m_q   <= bus.data_operandA;
                    lo_q  <= bus.data_operandB;
                    neg_q <= 1'b0;
                end else begin
                    m_q   <= b_mag;
                    lo_q  <= a_mag;
                    neg_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                end
            end else if (iter) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
                q1_q <= q1_d;
            end
            if (fix) begin
                unique case (op_q)
                    OP_MUL: begin
                        res_q <= lo_q;
                        exc_q <= mul_exc;
                    end
                    OP_DIV: begin
                        res_q <= q_fix;
                        // only INT_MIN / -1 yields a positive quotient with the top bit set
                        exc_q <= ~neg_q & lo_q[WIDTH-1];
                    end
                    default: begin
                        res_q <= '0;
                        exc_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomised self-checking bench for multdiv_sequencer against an
// arithmetic reference model.
module tb_multdiv_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multdiv_sequencer_if #(.WIDTH(32)) bus();

    multdiv_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     sa;
        int     sb;
        sa = a;
        sb = b;
        if (m) begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
            e = (p != longint'(int'(r)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = sa / sb;
            e = 1'b0;
        end
    endfunction

    // lat counts falling edges after the start edge until RDY is seen
    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic exc,
                         output int busy_low, output bit tail_ok);
        @(negedge clk);
        bus.ctrl_MULT = m;
        bus.ctrl_DIV = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clk);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        lat = -1;
        res = '0;
        exc = 1'b0;
        busy_low = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!bus.busy) busy_low++;
            if (bus.data_resultRDY) begin
                lat = n;
                res = bus.data_result;
                exc = bus.data_exception;
                break;
            end
        end
        @(negedge clk);
        tail_ok = !bus.data_resultRDY && !bus.busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.data_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", bus.data_result);
        end
        checks++;
        if (bus.data_exception !== 1'b0) begin
            errors++;
            $display("FAIL reset_exc: got %b expected 0", bus.data_exception);
        end
        checks++;
        if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_busy: got %b%b expected 00", bus.data_resultRDY, bus.busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_check(input string name, input bit m, input bit d,
                             input logic [31:0] a, input logic [31:0] b, input int exp_lat);
        int          lat;
        int          busy_low;
        bit          tail_ok;
        logic [31:0] res;
        logic [31:0] exp_r;
        logic        exc;
        logic        exp_e;
        model(m, a, b, exp_r, exp_e);
        do_op(m, d, a, b, lat, res, exc, busy_low, tail_ok);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency a=%h b=%h: got %0d expected %0d", name, a, b, lat, exp_lat);
        end
        checks++;
        if (res !== exp_r || exc !== exp_e) begin
            errors++;
            $display("FAIL %s_result a=%h b=%h: got %h/%b expected %h/%b",
                     name, a, b, res, exc, exp_r, exp_e);
        end
        checks++;
        if (busy_low != 0 || !tail_ok) begin
            errors++;
            $display("FAIL %s_busy a=%h b=%h: busy_low=%0d tail_ok=%0d expected 0/1",
                     name, a, b, busy_low, tail_ok);
        end
    endtask

    task automatic test_mult_directed();
        run_check("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 33);
        run_check("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 33);
        run_check("mul_intmin", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 33);
        run_check("mul_intmin_sq", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 33);
    endtask

    task automatic test_div_directed();
        run_check("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
        run_check("div_100/7", 1'b0, 1'b1, 32'd100, 32'd7, 33);
        run_check("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        run_check("div_zero", 1'b0, 1'b1, 32'd100, 32'd0, 1);
        run_check("div_intmin_by_2", 1'b0, 1'b1, 32'h8000_0000, 32'd2, 33);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) begin
                a = $signed(a) >>> $urandom_range(8, 30);
                b = $signed(b) >>> $urandom_range(8, 30);
            end
            run_check("rand_mul", 1'b1, 1'b0, a, b, 33);
        end
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $signed($urandom) >>> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd3;
            run_check("rand_div", 1'b0, 1'b1, a, b, 33);
        end
    endtask

    task automatic test_hold();
        logic [31:0] exp_r;
        logic        exp_e;
        run_check("hold_op", 1'b1, 1'b0, 32'd12345, 32'hFFFF_FF00, 33);
        model(1'b1, 32'd12345, 32'hFFFF_FF00, exp_r, exp_e);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.data_result !== exp_r || bus.data_exception !== exp_e || bus.data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL hold: got %h/%b rdy=%b expected %h/%b rdy=0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, exp_r, exp_e);
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] exp_r;
        logic        exp_e;
        int          lat;
        int          extra;
        logic [31:0] res;
        logic        exc;
        @(negedge clk);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'hFFFF_FFF6;
        model(1'b1, 32'd1000, 32'hFFFF_FFF6, exp_r, exp_e);
        @(posedge clk);
        #1;
        bus.ctrl_MULT = 1'b0;
        lat = -1;
        res = '0;
        exc = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            bus.ctrl_DIV = (n == 9);
            bus.data_operandB = 32'd7;
            if (bus.data_resultRDY) begin
                lat = n;
                res = bus.data_result;
                exc = bus.data_exception;
                break;
            end
        end
        bus.ctrl_DIV = 1'b0;
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.data_resultRDY || bus.busy) extra++;
        end
        checks++;
        if (lat != 33 || res !== exp_r || exc !== exp_e) begin
            errors++;
            $display("FAIL busy_start_ignored: got lat=%0d %h/%b expected lat=33 %h/%b",
                     lat, res, exc, exp_r, exp_e);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_start_extra: got %0d busy/rdy cycles expected 0", extra);
        end
        run_check("mul_wins", 1'b1, 1'b1, 32'h1234_5678, 32'd0, 33);
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'h7FFF_FFFF;
        bus.data_operandB = 32'h7FFF_FFFF;
        @(posedge clk);
        #1;
        bus.ctrl_MULT = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 ||
            bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h/%b rdy=%b busy=%b expected all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.data_resultRDY || bus.busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_no_rdy: got %0d busy/rdy cycles expected 0", bad);
        end
        run_check("after_reset_5x5", 1'b1, 1'b0, 32'd5, 32'd5, 33);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_random();
        test_hold();
        test_ignored_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
